// File: rtl/rsa_decrypt_engine.sv
// RSA decryption engine: recovers m = c^d mod n with right-to-left square-and-multiply.
// Each exponent bit costs one multiply cycle and one modulo cycle; d and n load over the shared data bus.
module rsa_decrypt_engine #(
   parameter int WIDTH   = 16,
   parameter int N_RESET = 3233,
   parameter int D_RESET = 2753
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [12:0]      data,
   input  logic             start,
   input  logic             update_d,
   input  logic             update_n,
   output logic             busy,
   output logic             out_valid,
   output logic             err,
   output logic [WIDTH-1:0] output_data
);

   localparam int DATA_W = 13;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      MUL,
      MOD,
      FINISH
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   n;
   logic [WIDTH-1:0]   d;
   logic [WIDTH-1:0]   cipher;
   logic [WIDTH-1:0]   base;
   logic [WIDTH-1:0]   result;
   logic [WIDTH-1:0]   exp_r;
   logic [2*WIDTH-1:0] prod_r;
   logic [2*WIDTH-1:0] prod_b;

   logic [WIDTH-1:0]   data_ext;
   logic [2*WIDTH-1:0] n_ext;
   logic [2*WIDTH-1:0] result_ext;
   logic [2*WIDTH-1:0] base_ext;
   logic [WIDTH-1:0]   exp_next;

   assign data_ext   = {{(WIDTH-DATA_W){1'b0}}, data};
   assign n_ext      = {{WIDTH{1'b0}}, n};
   assign result_ext = {{WIDTH{1'b0}}, result};
   assign base_ext   = {{WIDTH{1'b0}}, base};
   assign exp_next   = exp_r >> 1;

   // Control and datapath share one register block; out_valid and err default low every cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         n           <= WIDTH'(N_RESET);
         d           <= WIDTH'(D_RESET);
         cipher      <= '0;
         base        <= '0;
         result      <= '0;
         exp_r       <= '0;
         prod_r      <= '0;
         prod_b      <= '0;
         output_data <= '0;
         busy        <= 1'b0;
         out_valid   <= 1'b0;
         err         <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         err       <= 1'b0;
         case (state)
            IDLE: begin
               if (update_d || update_n) begin
                  if (update_d) d <= data_ext;
                  if (update_n) n <= data_ext;
               end else if (start) begin
                  if (n < WIDTH'(2)) begin
                     err <= 1'b1;
                  end else begin
                     cipher <= data_ext;
                     exp_r  <= d;
                     result <= WIDTH'(1);
                     busy   <= 1'b1;
                     state  <= LOAD;
                  end
               end
            end
            // Ciphertexts at or above n are reduced before the first multiply.
            LOAD: begin
               base  <= cipher % n;
               state <= (exp_r == '0) ? FINISH : MUL;
            end
            MUL: begin
               prod_r <= exp_r[0] ? (result_ext * base_ext) : result_ext;
               prod_b <= base_ext * base_ext;
               state  <= MOD;
            end
            MOD: begin
               result <= WIDTH'(prod_r % n_ext);
               base   <= WIDTH'(prod_b % n_ext);
               exp_r  <= exp_next;
               state  <= (exp_next == '0) ? FINISH : MUL;
            end
            FINISH: begin
               output_data <= result;
               out_valid   <= 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
